hiscore_uploader: RTL and testbench

Upload-side counterpart to the ROM/DIP download path in the arcade top level. On a save request it:
- pauses the game CPU;
- raises `ioctl_upload_req` to the HPS;
- answers the HPS `ioctl_rd` strobes by reading a window of game work RAM onto `ioctl_din`;
- releases the pause once the upload ends.

It sits between `hps_io` and the core's hiscore/NVRAM RAM port, in the `clk_sys` domain.

---
 rtl/hiscore_uploader.sv | 179 +++++++++++++++++
 tb/tb_hiscore_uploader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_uploader.sv
// hiscore_uploader
//   Upload-side companion to the ROM/DIP download path. A save request pauses
//   the game CPU, asks the HPS for an upload on index INDEX, then serves each
//   HPS byte-read strobe from a LEN-byte window of game work RAM starting at
//   BASE. The pause is released once the HPS ends the upload. Waiting for the
//   pause ack or for the HPS to start is bounded by TIMEOUT cycles.
//
// Build option:
//   HISCORE_CHECKSUM_EN - when defined, a read at offset LEN returns the
//   mod-256 sum of all in-range bytes served in the current transfer.
//
// Ports:
//   clk_sys, reset        clock, synchronous active-high reset
//   save_req              one-cycle save trigger
//   paused                CPU pause acknowledge
//   ioctl_upload/rd/addr/index   HPS upload interface (inputs)
//   ioctl_din             byte returned to the HPS
//   ioctl_upload_req      ask the HPS to start an upload
//   pause_req             hold the game CPU paused
//   ram_addr/ram_rd/ram_dout     game RAM read port (data 1 cycle after rd)
//   busy                  any state other than IDLE
//   aborted               one-cycle pulse on timeout abort
module hiscore_uploader #(
    parameter int              AW      = 16,
    parameter logic [AW-1:0]   BASE    = '0,
    parameter int              LEN     = 64,
    parameter logic [7:0]      INDEX   = 8'd4,
    parameter logic [23:0]     TIMEOUT = 24'd4_000_000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          save_req,
    input  logic          paused,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_index,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_upload_req,
    output logic          pause_req,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_dout,
    output logic          busy,
    output logic          aborted
);

    localparam logic [24:0] LEN_W = 25'(LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE_WAIT, S_REQ, S_XFER, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] to_cnt;
    logic        timeout_hit;
    logic        abort_now;
    logic        upload_q;

    // Read pipeline: [0] = RAM read issued this cycle, [1] = RAM data valid.
    logic [1:0]  vld_pipe;
    logic        oor_q;        // out-of-range strobe waiting to be presented
    logic [7:0]  oor_byte_q;
    logic [7:0]  oor_byte;
    logic [7:0]  din_q;
    logic        rd_ok;
    logic        in_range;

    assign timeout_hit = (to_cnt == TIMEOUT - 24'd1);
    assign rd_ok       = (state == S_XFER) && ioctl_rd && ioctl_upload &&
                         (ioctl_index == INDEX);
    assign in_range    = (ioctl_addr < LEN_W);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        abort_now = 1'b0;
        case (state)
            S_IDLE:       if (save_req) state_nxt = S_PAUSE_WAIT;
            S_PAUSE_WAIT: begin
                if (paused) state_nxt = S_REQ;
                else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                    abort_now = 1'b1;
                end
            end
            S_REQ: begin
                if (ioctl_upload && ioctl_index == INDEX) state_nxt = S_XFER;
                else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                    abort_now = 1'b1;
                end
            end
            // Only a real 1->0 transition ends the transfer.
            S_XFER:       if (upload_q && !ioctl_upload) state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // pause_req stays up through DONE so the CPU resumes the cycle after.
    always_comb begin
        pause_req        = (state == S_PAUSE_WAIT) || (state == S_REQ) ||
                           (state == S_XFER) || (state == S_DONE);
        ioctl_upload_req = (state == S_REQ);
        busy             = (state != S_IDLE);
    end

    // Timeout counter restarts on every state change, counts in the waits.
    always_ff @(posedge clk_sys) begin
        if (reset || state_nxt != state)
            to_cnt <= '0;
        else if (state == S_PAUSE_WAIT || state == S_REQ)
            to_cnt <= to_cnt + 24'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            aborted  <= 1'b0;
            upload_q <= 1'b0;
        end else begin
            aborted  <= abort_now;
            upload_q <= ioctl_upload;
        end
    end

`ifdef HISCORE_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk_sys) begin
        if (reset || (state == S_REQ && state_nxt == S_XFER))
            csum <= 8'h00;
        else if (vld_pipe[1])
            csum <= csum + ram_dout;
    end
`endif

    always_comb begin
        oor_byte = 8'hFF;
`ifdef HISCORE_CHECKSUM_EN
        if (ioctl_addr == LEN_W) oor_byte = csum;
`endif
    end

    // ---------------- read datapath ----------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vld_pipe   <= '0;
            ram_addr   <= BASE;
            oor_q      <= 1'b0;
            oor_byte_q <= 8'h00;
            din_q      <= 8'h00;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_ok && in_range};
            oor_q    <= rd_ok && !in_range;
            if (rd_ok && in_range)
                ram_addr <= BASE + ioctl_addr[AW-1:0];
            if (rd_ok && !in_range)
                oor_byte_q <= oor_byte;
            // A younger out-of-range strobe overrides older RAM data.
            if (oor_q)
                din_q <= oor_byte_q;
            else if (vld_pipe[1])
                din_q <= ram_dout;
        end
    end

    assign ram_rd = vld_pipe[0];
    // RAM data is forwarded the cycle it arrives and captured for holding.
    assign ioctl_din = vld_pipe[1] ? ram_dout : din_q;

endmodule

// File: tb/tb_hiscore_uploader.sv
module tb_hiscore_uploader;
    localparam int          AW    = 16;
    localparam logic [15:0] BASE  = 16'hFFE0;   // window wraps past 16'hFFFF
    localparam int          LEN   = 64;
    localparam logic [7:0]  INDEX = 8'd4;
    localparam int          TMO   = 100;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        save_req = 1'b0;
    logic        paused = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_index = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic        pause_req;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_dout;
    logic        busy;
    logic        aborted;

    hiscore_uploader #(
        .AW(AW), .BASE(BASE), .LEN(LEN), .INDEX(INDEX), .TIMEOUT(24'(TMO))
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .save_req(save_req), .paused(paused),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
        .ioctl_upload_req(ioctl_upload_req), .pause_req(pause_req),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_dout(ram_dout),
        .busy(busy), .aborted(aborted)
    );

    always #5 clk_sys = ~clk_sys;

    // Game RAM: synchronous read, data one cycle after ram_rd.
    logic [7:0] mem [0:65535];
    always @(posedge clk_sys) if (ram_rd) ram_dout <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct { int due; logic [7:0] val; } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;
    int n_ramrd = 0;
    int n_upreq = 0;
    logic [7:0] din_m = 8'h00;   // what the HPS should currently see
    logic [7:0] sum_m = 8'h00;   // sum of in-range bytes served this transfer

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk_sys); #1; end
    endtask

    function automatic logic [7:0] ref_byte(input logic [24:0] a);
        if (a < LEN) return mem[16'(BASE + a[15:0])];
`ifdef HISCORE_CHECKSUM_EN
        if (a == LEN) return sum_m;
`endif
        return 8'hFF;
    endfunction

    // One HPS strobe; accept=0 means the DUT must ignore it.
    task automatic hps_rd(input logic [24:0] a, input bit accept);
        logic [7:0] e;
        if (accept) begin
            e = ref_byte(a);
            din_m = e;
            if (a < LEN) sum_m = sum_m + e;
        end
        sbq.push_back('{due: cyc + 2, val: din_m});
        sbq.push_back('{due: cyc + 3, val: din_m});
        ioctl_addr = a;
        ioctl_rd = 1'b1;
        step();
        ioctl_rd = 1'b0;
        step(2 + $urandom_range(0, 2));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin step(); n++; end
        check("sb_drain", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic start_xfer(input int pdly);
        check("idle_busy", busy, 0);
        check("pause_pre", pause_req, 0);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        check("pause_rise", pause_req, 1);
        check("busy_rise", busy, 1);
        repeat (pdly) begin
            check("upreq_wait", ioctl_upload_req, 0);
            step();
        end
        paused = 1'b1;
        step();
        check("upreq_rise", ioctl_upload_req, 1);
        ioctl_upload = 1'b1;
        ioctl_index = INDEX;
        sum_m = 8'h00;
        step();
        step(2);
        check("upreq_fall", ioctl_upload_req, 0);
    endtask

    task automatic end_xfer();
        drain();
        ioctl_upload = 1'b0;
        step();
        check("pause_done", pause_req, 1);
        check("busy_done", busy, 1);
        step();
        check("pause_rel", pause_req, 0);
        check("busy_rel", busy, 0);
        paused = 1'b0;
        step();
    endtask

    initial begin
        int up0;
        int rd0;
        fork
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog");
            end
        join_none
        fork
            begin : monitor
                exp_t e;
                logic upreq_d = 1'b0;
                forever begin
                    @(negedge clk_sys);
                    if (ram_rd) n_ramrd++;
                    if (ioctl_upload_req && !upreq_d) n_upreq++;
                    upreq_d = ioctl_upload_req;
                    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                        e = sbq.pop_front();
                        check("ioctl_din", ioctl_din, e.val);
                    end
                end
            end
        join_none

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < LEN; i++) mem[16'(BASE + 16'(i))] = 8'(i) ^ 8'h5A;

        // Reset values
        step(3);
        check("rst_din", ioctl_din, 8'h00);
        check("rst_upreq", ioctl_upload_req, 0);
        check("rst_pause", pause_req, 0);
        check("rst_ram_rd", ram_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_aborted", aborted, 0);
        check("rst_ram_addr", ram_addr, BASE);
        reset = 1'b0;
        step();

        // Nominal transfer, out-of-range reads, and an ignored save_req
        up0 = n_upreq;
        rd0 = n_ramrd;
        start_xfer(10);
        for (int i = 0; i < LEN; i++) begin
            hps_rd(25'(i), 1'b1);
            if (i == 30) begin
                save_req = 1'b1; step(); save_req = 1'b0; step();
            end
        end
        hps_rd(25'(LEN), 1'b1);
        hps_rd(25'd1000, 1'b1);
        hps_rd(25'(LEN + 1), 1'b1);
        end_xfer();
        check("one_upreq", n_upreq - up0, 1);
        check("ramrd_count", n_ramrd - rd0, LEN);

        // Timeout waiting for pause ack
        save_req = 1'b1; step(); save_req = 1'b0;
        step(TMO - 1);
        check("to1_pre_abort", aborted, 0);
        check("to1_pre_busy", busy, 1);
        step();
        check("to1_abort", aborted, 1);
        check("to1_pause", pause_req, 0);
        check("to1_busy", busy, 0);
        step();
        check("to1_pulse", aborted, 0);

        // Timeout waiting for the HPS in REQ
        save_req = 1'b1; step(); save_req = 1'b0;
        paused = 1'b1;
        step();
        check("to2_upreq", ioctl_upload_req, 1);
        step(TMO - 1);
        check("to2_pre_abort", aborted, 0);
        check("to2_pre_upreq", ioctl_upload_req, 1);
        step();
        check("to2_abort", aborted, 1);
        check("to2_upreq_clr", ioctl_upload_req, 0);
        check("to2_pause", pause_req, 0);
        check("to2_busy", busy, 0);
        paused = 1'b0;
        step(2);

        // Foreign index during REQ, then random transfers
        save_req = 1'b1; step(); save_req = 1'b0;
        paused = 1'b1;
        step();
        ioctl_upload = 1'b1;
        ioctl_index = 8'd0;
        rd0 = n_ramrd;
        for (int k = 0; k < 4; k++) hps_rd(25'($urandom_range(0, LEN - 1)), 1'b0);
        drain();
        check("foreign_no_rd", n_ramrd - rd0, 0);
        check("foreign_stay_req", ioctl_upload_req, 1);
        ioctl_index = INDEX;
        sum_m = 8'h00;
        step(2);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                for (int i = 0; i < LEN; i++) mem[16'(BASE + 16'(i))] = 8'($urandom);
                start_xfer($urandom_range(1, 20));
            end
            for (int k = 0; k < 40; k++) begin
                if (k == 20) begin
                    ioctl_index = 8'd0;
                    hps_rd(25'($urandom_range(0, LEN - 1)), 1'b0);
                    ioctl_index = INDEX;
                end
                if ($urandom_range(0, 9) == 0) hps_rd(25'($urandom_range(LEN, 2000)), 1'b1);
                else hps_rd(25'($urandom_range(0, LEN + 1)), 1'b1);
            end
            hps_rd(25'(LEN), 1'b1);
            end_xfer();
        end

        // Reset in the middle of a transfer, then a clean transfer
        for (int i = 0; i < LEN; i++) mem[16'(BASE + 16'(i))] = 8'(i) ^ 8'h5A;
        start_xfer(3);
        for (int i = 0; i < 20; i++) hps_rd(25'(i), 1'b1);
        drain();
        reset = 1'b1;
        step();
        check("mid_rst_pause", pause_req, 0);
        check("mid_rst_din", ioctl_din, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_upreq", ioctl_upload_req, 0);
        check("mid_rst_addr", ram_addr, BASE);
        reset = 1'b0;
        ioctl_upload = 1'b0;
        paused = 1'b0;
        din_m = 8'h00;
        step(2);
        up0 = n_upreq;
        start_xfer(10);
        for (int i = 0; i < LEN; i++) hps_rd(25'(i), 1'b1);
        hps_rd(25'(LEN), 1'b1);
        end_xfer();
        check("post_rst_upreq", n_upreq - up0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
